// File: rtl/isa_camac_pkg.sv
// Shared constants and types for the ISA-to-CAMAC write assembler.
// The word width and the holding-register state encoding live here.
package isa_camac_pkg;
  localparam int BYTE_W       = 8;
  localparam int CAMAC_WORD_W = 24;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;
endpackage

// File: rtl/isa_byte_lane.sv
// One byte lane of the staging register, plus its "written since last commit" mask bit.
// An accepted commit clearing the mask takes priority over a same-cycle write.
module isa_byte_lane
  import isa_camac_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clr_mask,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] data,
  output logic              mask
);

  // lane data and mask registers
  always_ff @(posedge clk) begin
    if (rst) begin
      data <= {BYTE_W{1'b0}};
      mask <= 1'b0;
    end else begin
      if (wr_en) begin
        data <= din;
      end else begin
        data <= data;
      end
      if (clr_mask) begin
        mask <= 1'b0;
      end else if (wr_en) begin
        mask <= 1'b1;
      end else begin
        mask <= mask;
      end
    end
  end

endmodule

// File: rtl/isa_camac_write_assembler.sv
// Steers ISA byte writes into a wide staging word and offers committed words
// to the CAMAC write sequencer via a one-entry valid/ready holding register.
module isa_camac_write_assembler
  import isa_camac_pkg::*;
#(
  parameter int BYTES = CAMAC_WORD_W / BYTE_W,
  parameter int SEL_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BYTE_W-1:0]     isa_data,
  input  logic                  isa_wr,
  input  logic [SEL_W-1:0]      isa_byte_sel,
  input  logic                  isa_commit,
  input  logic                  ovr_clr,
  output logic [BYTE_W*BYTES-1:0] camac_data,
  output logic                  camac_valid,
  input  logic                  camac_ready,
  output logic [BYTES-1:0]      byte_mask,
  output logic                  overrun
);

  hold_state_t                 state;
  hold_state_t                 state_next;
  logic                        accept;
  logic                        drop;
  logic [BYTES-1:0]            lane_wr;
  logic [BYTE_W*BYTES-1:0]     staging;
  logic [BYTE_W*BYTES-1:0]     staged_next;

  for (genvar i = 0; i < BYTES; i++) begin : g_lane
    assign lane_wr[i] = isa_wr && (isa_byte_sel == SEL_W'(i));
    // Forward a same-cycle write into the word being committed.
    assign staged_next[BYTE_W*i +: BYTE_W] =
      lane_wr[i] ? isa_data : staging[BYTE_W*i +: BYTE_W];

    isa_byte_lane u_lane (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (lane_wr[i]),
      .clr_mask (accept),
      .din      (isa_data),
      .data     (staging[BYTE_W*i +: BYTE_W]),
      .mask     (byte_mask[i])
    );
  end

  // holding FSM next-state and commit decision
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      HOLD_EMPTY: begin
        if (isa_commit) begin
          accept     = 1'b1;
          state_next = HOLD_FULL;
        end else begin
          state_next = HOLD_EMPTY;
        end
      end
      HOLD_FULL: begin
        if (isa_commit && camac_ready) begin
          accept     = 1'b1;
          state_next = HOLD_FULL;
        end else if (isa_commit) begin
          drop       = 1'b1;
          state_next = HOLD_FULL;
        end else if (camac_ready) begin
          state_next = HOLD_EMPTY;
        end else begin
          state_next = HOLD_FULL;
        end
      end
      default: begin
        state_next = HOLD_EMPTY;
      end
    endcase
  end

  // state, holding word and sticky overrun registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HOLD_EMPTY;
      camac_data <= {(BYTE_W*BYTES){1'b0}};
      overrun    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        camac_data <= staged_next;
      end else begin
        camac_data <= camac_data;
      end
      // a new overrun beats a same-cycle clear
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

  assign camac_valid = (state == HOLD_FULL);

endmodule
